// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP capture: packs byte pairs into RGB565 and gates capture on frame edges.
// Define CAP_TESTPAT_EN to replace camera pixels with colour bars.
module ov5640_dvp_capture #(
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int FRAME_SKIP = 10,
  parameter bit VS_POL     = 1'b1
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        cfg_done,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    WAIT_VS,
    ACTIVE
  } state_t;

  localparam logic [10:0] H_EXP = 11'(H_ACT);
  localparam logic [10:0] V_EXP = 11'(V_ACT);
  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [7:0] SKIP_LAST =
    (FRAME_SKIP == 0) ? 8'd0 : 8'(FRAME_SKIP - 1);

  state_t      state;
  logic        r1_vsync;
  logic        r1_href;
  logic [7:0]  r1_data;
  logic        vs_act_d;
  logic        href_d;
  logic        phase;
  logic [7:0]  hi_byte;
  logic [7:0]  skip_cnt;
  logic [10:0] col_cnt;
  logic [10:0] row_cnt;

  logic        vs_act;
  logic        vs_rise;
  logic        vs_fall;
  logic        href_fall;
  logic [10:0] rows_end;
  logic [15:0] pix_word;

  assign vs_act    = (r1_vsync == VS_POL);
  assign vs_rise   = vs_act & ~vs_act_d;
  assign vs_fall   = ~vs_act & vs_act_d;
  assign href_fall = href_d & ~r1_href;
  // a line still open when vsync asserts counts as a row
  assign rows_end  = row_cnt + {10'd0, href_d};

`ifdef CAP_TESTPAT_EN
  localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;

  logic [10:0] bar_q;
  logic [2:0]  bar_sel;
  logic [15:0] bar_rgb;

  assign bar_q   = col_cnt / 11'(BAR_W);
  assign bar_sel = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];

  always_comb begin
    bar_rgb = 16'h0000;
    unique case (bar_sel)
      3'd0: bar_rgb = 16'hFFFF;
      3'd1: bar_rgb = 16'hFFE0;
      3'd2: bar_rgb = 16'h07FF;
      3'd3: bar_rgb = 16'h07E0;
      3'd4: bar_rgb = 16'hF81F;
      3'd5: bar_rgb = 16'hF800;
      3'd6: bar_rgb = 16'h001F;
      3'd7: bar_rgb = 16'h0000;
    endcase
  end

  assign pix_word = (capture_en & cfg_done) ?
    bar_rgb : {hi_byte, r1_data};
`else
  assign pix_word = {hi_byte, r1_data};
`endif

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state       <= IDLE;
      r1_vsync    <= 1'b0;
      r1_href     <= 1'b0;
      r1_data     <= 8'd0;
      vs_act_d    <= 1'b0;
      href_d      <= 1'b0;
      phase       <= 1'b0;
      hi_byte     <= 8'd0;
      skip_cnt    <= 8'd0;
      col_cnt     <= 11'd0;
      row_cnt     <= 11'd0;
      pix_data    <= 16'd0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      r1_vsync    <= cam_vsync;
      r1_href     <= cam_href;
      r1_data     <= cam_data;
      vs_act_d    <= vs_act;
      href_d      <= r1_href;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (!cfg_done) begin
        state <= IDLE;
        phase <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            skip_cnt <= 8'd0;
            state    <= (FRAME_SKIP == 0) ? WAIT_VS : SKIP;
          end
          SKIP: begin
            if (vs_fall) begin
              skip_cnt <= skip_cnt + 8'd1;
              if (skip_cnt == SKIP_LAST)
                state <= WAIT_VS;
            end
          end
          WAIT_VS: begin
            if (vs_fall && capture_en) begin
              state       <= ACTIVE;
              frame_start <= 1'b1;
              line_err    <= 1'b0;
              row_cnt     <= 11'd0;
              col_cnt     <= 11'd0;
              phase       <= 1'b0;
            end
          end
          ACTIVE: begin
            if (vs_rise) begin
              state      <= WAIT_VS;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
              phase      <= 1'b0;
              col_cnt    <= 11'd0;
              if (rows_end != V_EXP ||
                  (href_d && col_cnt != H_EXP))
                line_err <= 1'b1;
            end else if (r1_href) begin
              phase <= ~phase;
              if (!phase) begin
                hi_byte <= r1_data;
              end else begin
                pix_data  <= pix_word;
                pix_valid <= 1'b1;
                if (col_cnt != CNT_MAX)
                  col_cnt <= col_cnt + 11'd1;
              end
            end else if (href_fall) begin
              phase   <= 1'b0;
              col_cnt <= 11'd0;
              if (col_cnt != H_EXP)
                line_err <= 1'b1;
              if (row_cnt != CNT_MAX)
                row_cnt <= row_cnt + 11'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Randomized bench for ov5640_dvp_capture on a scaled 16x4 frame.
// Reference model tracks frames, skip count and expected pixels by rule.
module tb_ov5640_dvp_capture;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int SK = 2;

  logic        sclk = 1'b0;
  logic        s_rst = 1'b1;
  logic        cfg_done = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        frame_start;
  logic        frame_done;
  logic        line_err;
  logic [7:0]  frame_cnt;

  ov5640_dvp_capture #(
    .H_ACT(H),
    .V_ACT(V),
    .FRAME_SKIP(SK),
    .VS_POL(1'b1)
  ) dut (
    .sclk(sclk),
    .s_rst(s_rst),
    .cfg_done(cfg_done),
    .capture_en(capture_en),
    .cam_vsync(cam_vsync),
    .cam_href(cam_href),
    .cam_data(cam_data),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .line_err(line_err),
    .frame_cnt(frame_cnt)
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_cyc = -100;
  int n_fs = 0;
  int n_fd = 0;
  int n_pix = 0;
  int m_fs = 0;
  int m_fd = 0;
  int m_pix = 0;
  int m_n = 0;
  int m_fcnt = 0;
  bit m_err = 1'b0;
  logic [15:0] q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int idx,
                                          input logic [7:0] b0,
                                          input logic [7:0] b1);
`ifdef CAP_TESTPAT_EN
    int k;
    k = idx / (H / 8);
    if (k > 7) k = 7;
    case (k)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
`else
    return {b0, b1};
`endif
  endfunction

  always @(posedge sclk) cyc <= cyc + 1;

  always @(posedge sclk) begin
    #1;
    if (frame_start) n_fs++;
    if (frame_done) n_fd++;
    if (pix_valid) begin
      n_pix++;
      chk("pix_q", 32'(q.size() > 0), 1);
      if (q.size() > 0) chk("pix", pix_data, q.pop_front());
    end
    if (cyc == lat_cyc + 1) chk("lat_early", pix_valid, 0);
    if (cyc == lat_cyc + 2) chk("lat_hit", pix_valid, 1);
    if (cyc == lat_cyc + 3) chk("lat_width", pix_valid, 0);
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic vs_pulse_check();
    cam_vsync = 1'b1;
    repeat (4) tick();
    chk("fcnt", frame_cnt, m_fcnt);
    chk("lerr", line_err, m_err);
    chk("fs_cnt", n_fs, m_fs);
    chk("fd_cnt", n_fd, m_fd);
  endtask

  task automatic send_frame(input int nlines, input int short_ln,
                            input bit cap, input bit cap_mid,
                            input int rst_ln, input bit lat);
    bit took;
    int np;
    logic [7:0] b0;
    logic [7:0] b1;
    vs_pulse_check();
    capture_en = cap;
    tick();
    cam_vsync = 1'b0;
    m_n++;
    took = (m_n > SK) && cap;
    if (took) begin
      m_fs++;
      m_err = 1'b0;
    end
    repeat (3) tick();
    if (took) chk("lerr_clr", line_err, 0);
    for (int ln = 0; ln < nlines; ln++) begin
      np = (ln == short_ln) ? H - 1 : H;
      if (ln == 1) capture_en = cap_mid;
      for (int p = 0; p < np; p++) begin
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        if (lat && ln == 0 && p == 0) begin
          b0 = 8'hF8;
          b1 = 8'h00;
        end
        if (took) begin
          q.push_back(exp_pix(p, b0, b1));
          m_pix++;
        end
        tick();
        cam_href = 1'b1;
        cam_data = b0;
        tick();
        cam_data = b1;
        if (lat && ln == 0 && p == 0) lat_cyc = cyc;
        if (ln == rst_ln && p == 2) begin
          #3 s_rst = 1'b1;
          #1;
          chk("rst_pv", pix_valid, 0);
          chk("rst_fcnt", frame_cnt, 0);
          chk("rst_lerr", line_err, 0);
          s_rst = 1'b0;
          m_pix -= q.size();
          q.delete();
          m_n = 0;
          m_fcnt = 0;
          m_err = 1'b0;
          took = 1'b0;
        end
      end
      if (ln == short_ln) begin
        tick();
        cam_data = 8'($urandom);
      end
      tick();
      cam_href = 1'b0;
      cam_data = 8'($urandom);
      repeat (4) tick();
    end
    if (took) begin
      m_fcnt = (m_fcnt + 1) % 256;
      m_fd++;
      if (nlines != V || (short_ln >= 0 && short_ln < nlines))
        m_err = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    chk("rst_data", pix_data, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", line_err, 0);
    chk("rst_cnt", frame_cnt, 0);
    s_rst = 1'b0;
    cfg_done = 1'b1;
    capture_en = 1'b1;
    repeat (3) tick();
    send_frame(V, -1, 1, 1, -1, 0);
    send_frame(V, -1, 1, 1, -1, 0);
    send_frame(V, -1, 1, 1, -1, 1);
    send_frame(V, -1, 1, 1, -1, 0);
    send_frame(V, 1, 1, 1, -1, 0);
    send_frame(V, -1, 1, 1, -1, 0);
    send_frame(V, -1, 0, 1, -1, 0);
    send_frame(V, -1, 1, 1, -1, 0);
    send_frame(V - 1, -1, 1, 1, -1, 0);
    send_frame(V, -1, 1, 1, 1, 0);
    send_frame(V, -1, 1, 1, -1, 0);
    send_frame(V, -1, 1, 1, -1, 0);
    send_frame(V, 2, 1, 1, -1, 0);
    vs_pulse_check();
    repeat (4) tick();
    chk("q_empty", q.size(), 0);
    chk("pix_total", n_pix, m_pix);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
